// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-write-side signals of fifo_wr_arbiter, bundled as one interface.
// master = the arbiter, slave = the producers plus the FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [GW-1:0]                 grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-requester saturating beat counters (beat_count, stats_clr).
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_wr_arbiter_if.master     bus
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [NUM_REQ*16-1:0] beat_count
`endif
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [7:0]    LAST_BEAT  = 8'(MAX_BURST - 1);
  localparam logic [GW-1:0] LAST_RESET = GW'(NUM_REQ - 1);

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;

  logic [GW-1:0] pick;
  logic          grant_valid;
  logic          active;
  logic          beat;

  // Scan downward so the smallest offset from last_q is the one that sticks.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pick = grant_q;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (bus.req_valid[(int'(last_q) + off) % NUM_REQ]) begin
        pick = GW'((int'(last_q) + off) % NUM_REQ);
      end
    end
  end

  // Handshake outputs are combinational from the registered grant; rst blocks any write.
  always_comb begin
    grant_valid      = bus.req_valid[grant_q];
    active           = (state_q == BURST) && !rst;
    beat             = active && grant_valid && !bus.fifo_full;
    bus.req_ready    = '0;
    if (active && !bus.fifo_full) begin
      bus.req_ready[grant_q] = 1'b1;
    end
    bus.fifo_wr_en   = beat;
    bus.fifo_wr_data = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    bus.grant_id     = grant_q;
    bus.busy         = (state_q == BURST);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (!grant_valid) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (!bus.fifo_full) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= LAST_RESET;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (beat && (grant_q == GW'(i)) && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
      beat_count[i*16 +: 16] = cnt_q[i];
    end
  end

  // NOTE: the counter array is architecturally visible, so it is reset element by element like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run against a behavioural round-robin model.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic              stats_clr;
  logic [NR*16-1:0]  beat_count;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .beat_count(beat_count)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [3:0] v, input logic f, input logic [31:0] d, input logic r);
    bus.req_valid = v;
    bus.fifo_full = f;
    bus.req_data  = d;
    rst           = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(4'h0, 1'b0, 32'h0, 1'b1);
`ifdef FIFO_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Behavioural model: who holds the port, how many beats it has taken, who went last.
  bit m_burst;
  int m_g, m_n, m_last;

  task automatic model_reset();
    m_burst = 0; m_g = 0; m_n = 0; m_last = NR - 1;
  endtask

  task automatic model_advance(input logic [3:0] v, input logic f, input logic r);
    if (r) begin
      model_reset();
    end else if (!m_burst) begin
      for (int off = 1; off <= NR; off++) begin
        if (v[(m_last + off) % NR]) begin
          m_g = (m_last + off) % NR;
          m_n = 0;
          m_burst = 1;
          break;
        end
      end
    end else if (!v[m_g]) begin
      m_burst = 0;
      m_last  = m_g;
    end else if (!f) begin
      m_n++;
      if (m_n == MB) begin
        m_burst = 0;
        m_last  = m_g;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        full;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic        wr;
    logic [7:0]  wd;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;

  vec_t tv [12];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [1:0] grants [$];
    int         idle_cnt;
    logic [3:0] v;
    logic       f, r;
    logic [31:0] d;

    // Plan 1: single producer, three words, then valid drops. Then wrap-scan from last_grant=1.
    tv[0]  = '{4'b0001, 1'b0, 32'h00000011, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b0};
    tv[1]  = '{4'b0001, 1'b0, 32'h00000011, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1};
    tv[2]  = '{4'b0001, 1'b0, 32'h00000022, 4'b0001, 1'b1, 8'h22, 2'd0, 1'b1};
    tv[3]  = '{4'b0001, 1'b0, 32'h00000033, 4'b0001, 1'b1, 8'h33, 2'd0, 1'b1};
    tv[4]  = '{4'b0000, 1'b0, 32'h00000033, 4'b0001, 1'b0, 8'h33, 2'd0, 1'b1};
    tv[5]  = '{4'b0000, 1'b0, 32'h00000033, 4'b0000, 1'b0, 8'h33, 2'd0, 1'b0};
    tv[6]  = '{4'b0010, 1'b0, 32'h0000AA00, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[7]  = '{4'b0010, 1'b0, 32'h0000AA00, 4'b0010, 1'b1, 8'hAA, 2'd1, 1'b1};
    tv[8]  = '{4'b1001, 1'b0, 32'hBB0000CC, 4'b0010, 1'b0, 8'h00, 2'd1, 1'b1};
    tv[9]  = '{4'b1001, 1'b0, 32'hBB0000CC, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
    tv[10] = '{4'b1001, 1'b0, 32'hBB0000CC, 4'b1000, 1'b1, 8'hBB, 2'd3, 1'b1};
    tv[11] = '{4'b0000, 1'b0, 32'hBB0000CC, 4'b1000, 1'b0, 8'hBB, 2'd3, 1'b1};

    do_reset();
    @(negedge clk);
    check("reset_busy",  bus.busy,       0);
    check("reset_ready", bus.req_ready,  0);
    check("reset_wr_en", bus.fifo_wr_en, 0);
    check("reset_grant", bus.grant_id,   0);
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      set_in(tv[i].v, tv[i].full, tv[i].d, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), bus.req_ready,    tv[i].rdy);
      check($sformatf("vec%0d_wr_en", i), bus.fifo_wr_en,   tv[i].wr);
      check($sformatf("vec%0d_wdata", i), bus.fifo_wr_data, tv[i].wd);
      check($sformatf("vec%0d_grant", i), bus.grant_id,     tv[i].gid);
      check($sformatf("vec%0d_busy",  i), bus.busy,         tv[i].busy);
      next_cycle();
    end

    // All four requesters continuously valid: 0,1,2,3,0 with four beats each and one idle cycle between.
    do_reset();
    set_in(4'hF, 1'b0, 32'h44332211, 1'b0);
    idle_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.fifo_wr_en) grants.push_back(bus.grant_id);
      else if (!bus.busy) idle_cnt++;
      next_cycle();
    end
    check("rr_beats", grants.size(), 20);
    check("rr_idle",  idle_cnt,      5);
    for (int k = 0; k < 20 && k < grants.size(); k++) begin
      check($sformatf("rr_grant%0d", k), grants[k], (k / 4) % 4);
    end

    // Requester 2, fifo_full for 3 cycles after beat 2: stall, then 2 more beats and rotate.
    do_reset();
    set_in(4'b0100, 1'b0, 32'h00CC0000, 1'b0);
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("stall_pre_beat%0d", c), bus.fifo_wr_en, 1);
      next_cycle();
    end
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall_ready%0d", c), bus.req_ready,  0);
      check($sformatf("stall_wr_en%0d", c), bus.fifo_wr_en, 0);
      check($sformatf("stall_grant%0d", c), bus.grant_id,   2);
      check($sformatf("stall_busy%0d",  c), bus.busy,       1);
      next_cycle();
    end
    bus.fifo_full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("stall_post_beat%0d", c), bus.fifo_wr_en, 1);
      check($sformatf("stall_post_data%0d", c), bus.fifo_wr_data, 8'hCC);
      next_cycle();
    end
    @(negedge clk);
    check("stall_end_busy",  bus.busy,       0);
    check("stall_end_wr_en", bus.fifo_wr_en, 0);
    next_cycle();

    // rst during beat 3: no write on that edge, then reset priority hands the port to requester 0.
    do_reset();
    set_in(4'b0010, 1'b0, 32'h0000AA55, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wr_en", bus.fifo_wr_en, 0);
    check("rst_mid_ready", bus.req_ready,  0);
    next_cycle();
    set_in(4'b0011, 1'b0, 32'h0000AA55, 1'b0);
    @(negedge clk);
    check("rst_after_busy", bus.busy, 0);
    next_cycle();
    @(negedge clk);
    check("rst_after_grant", bus.grant_id,   0);
    check("rst_after_wr_en", bus.fifo_wr_en, 1);
    check("rst_after_data",  bus.fifo_wr_data, 8'h55);
    next_cycle();

`ifdef FIFO_ARB_STATS_EN
    begin : stats_test
      int beats;
      do_reset();
      set_in(4'b0010, 1'b0, 32'h00007700, 1'b0);
      beats = 0;
      for (int c = 0; c < 20 && beats < 5; c++) begin
        @(negedge clk);
        if (bus.fifo_wr_en) beats++;
        next_cycle();
      end
      check("stats_beats_seen", beats, 5);
      stats_clr = 1'b1;
      @(negedge clk);
      check("stats_before_clr", beat_count[16 +: 16], 5);
      check("stats_clr_beat",   bus.fifo_wr_en,       1);
      next_cycle();
      stats_clr = 1'b0;
      bus.req_valid = 4'b0000;
      @(negedge clk);
      check("stats_after_clr", beat_count[16 +: 16], 0);
      check("stats_others",    {beat_count[48 +: 16], beat_count[32 +: 16], beat_count[0 +: 16]}, 0);
      next_cycle();
    end
`endif

    // Randomized run against the behavioural model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      v = 4'($urandom) | 4'($urandom);
      f = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 199) == 0);
      d = $urandom;
      set_in(v, f, d, r);
      @(negedge clk);
      check("rnd_ready", bus.req_ready,
            (m_burst && !r && !f) ? (32'd1 << m_g) : 32'd0);
      check("rnd_wr_en", bus.fifo_wr_en, (m_burst && !r && v[m_g] && !f) ? 1 : 0);
      check("rnd_wdata", bus.fifo_wr_data, (d >> (8 * m_g)) & 32'hFF);
      check("rnd_grant", bus.grant_id, m_g);
      check("rnd_busy",  bus.busy, m_burst);
      model_advance(v, f, r);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers.
- Each producer has a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's wr_en/data_in from the granted producer.
- The FIFO's full flag back-pressures the granted producer.
- Sits directly in front of the FIFO write side.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, data width, equal to the FIFO DATA_WIDTH
- MAX_BURST, 4, maximum beats per grant before forced rotation (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept; a beat transfers when valid&ready
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- grant_id  out  $clog2(NUM_REQ)  index of the currently granted requester
- busy  out  1  high while in BURST

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, grant_id=0, beat_cnt=0, last_grant=NUM_REQ-1, so requester 0 has top priority first.
  - busy=0, req_ready=0, fifo_wr_en=0.
- FSM IDLE:
  - If any req_valid is high, select the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register the selection into grant_id, clear beat_cnt, go to BURST.
  - Arbitration latency is 1 cycle; no beat is accepted in IDLE.
  - If no req_valid is high, stay in IDLE.
- FSM BURST:
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & !fifo_full. These are combinational from the registered grant.
  - fifo_wr_data = req_data slice of grant_id, driven regardless of wr_en.
  - On a beat: beat_cnt += 1. If beat_cnt was MAX_BURST-1, go to IDLE and set last_grant=grant_id.
  - If req_valid[grant_id] is 0 in a cycle: go to IDLE, set last_grant=grant_id. No beat occurs that cycle.
  - If fifo_full=1 and valid=1: stall. Hold grant and beat_cnt, and do not advance toward rotation.
- Requester contract: req_data must be stable while valid is high and ready is low. The arbiter never writes when fifo_full=1, so it never overflows the FIFO.
- Valid changes on non-granted requesters never affect the current burst.
- beat_cnt is 8 bits and never wraps, because MAX_BURST ≤ 255.
- Fairness: a continuously requesting producer waits at most (NUM_REQ-1)*(MAX_BURST+1) beat-cycles plus full-stall cycles.
- rst asserted mid-burst: everything returns to reset values at that edge. An in-flight beat on that edge is not written, because fifo_wr_en is forced 0 while rst=1.
- NUM_REQ=1: the grant is always 0; rotation still passes through IDLE for 1 cycle.
- Outputs idle low: busy=0, req_ready=0, fifo_wr_en=0; grant_id holds its last value.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds output beat_count of width NUM_REQ*16, one 16-bit counter per requester.
  - A counter increments on each accepted beat of that requester and saturates at 16'hFFFF.
  - Counters clear on rst.
  - Adds input stats_clr (1 bit), which synchronously zeroes all counters. If a beat coincides with stats_clr, clear wins.
- Not defined: neither port exists and no counter logic is generated. Arbitration behaviour is identical.

Test Plan:
- Reset, then req_valid=4'b0001 with 3 words 0x11,0x22,0x33 -> grant_id=0 one cycle later; fifo_wr_en high for 3 consecutive cycles writing 0x11,0x22,0x33; back to IDLE on the cycle valid drops.
- All 4 requesters valid continuously, MAX_BURST=4 -> grants 0,1,2,3,0; exactly 4 beats each; one idle arbitration cycle between bursts.
- Requester 2 granted, fifo_full asserted for 3 cycles after beat 2 -> req_ready[2]=0 and fifo_wr_en=0 during those cycles; burst resumes with beat_cnt=2 and ends after 2 more beats.
- last_grant=1, req_valid=4'b1001 -> grant goes to 3 (wrap scan from 2), not 0.
- rst pulsed during beat 3 of a burst -> fifo_wr_en=0 on that edge; next grant goes to requester 0 per reset priority.
- FIFO_ARB_STATS_EN: 5 beats from requester 1, then stats_clr coinciding with a 6th beat -> counter reads 5 before the clear and 0 after; other counters stay 0.
